uart_rx_deframer: RTL and testbench
===================================

# uart_rx_deframer

Receive-side counterpart of the UART transmit chain. Samples the serial line at 16× baud, detects the start bit, shifts in 7 or 8 data bits LSB first, optionally checks parity, validates 1 or 2 stop bits, and presents the recovered byte with status flags. Sits between the pad-side `RxIn` line and the receive FIFO or host logic. Frame options match the transmitter's configuration inputs.

## Interface
Parameters:
- `OVERSAMPLE`, 16: sample ticks per bit period; must be even and ≥ 8.
- `SYNC_STAGES`, 2: metastability flops on `RxIn`.

Ports:
- `Clock` in 1: system clock; the only clock.
- `Reset` in 1: synchronous reset, active-high.
- `SampleTick` in 1: one-`Clock` pulse at 16× baud from the baud generator; all bit timing advances only on ticks.
- `RxIn` in 1: asynchronous serial line; idle high.
- `ParityType` in 2: 00 none, 01 odd, 10 even, 11 none.
- `StopBits` in 1: 0 = one stop bit, 1 = two stop bits.
- `DataLength` in 1: 0 = 7 data bits, 1 = 8 data bits.
- `DataOut` out 8: received data; bit 7 forced 0 in 7-bit mode; reset 0.
- `DataValid` out 1: one-`Clock` pulse when a frame completes; reset 0.
- `ParityError` out 1: parity mismatch for the frame in `DataOut`; reset 0.
- `StopError` out 1: a stop-bit sample was low; reset 0.
- `ActiveFlag` out 1: high from confirmed start bit to frame end; reset 0.
- `DoneFlag` out 1: high when idle and ready; reset 1.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: on a falling edge of the synchronised line, clear the tick counter, latch `ParityType`, `StopBits`, and `DataLength` into frame registers, go to START. Configuration changes mid-frame have no effect.
- START: at tick `OVERSAMPLE/2 - 1` (mid-bit), sample the line. If low, start is confirmed: set `ActiveFlag`=1, set `DoneFlag`=0, reset the tick counter, go to DATA. If high, it is a false start: return to IDLE with no flags changed.
- DATA: sample at tick `OVERSAMPLE-1` of each bit and shift in LSB first. The bit counter runs 0..6 or 0..7 per the latched length. After the last bit, go to PARITY if parity is enabled, otherwise go to STOP.
- PARITY: sample one bit. Odd parity requires data XOR parity = 1. Even parity requires data XOR parity = 0. Parity covers only the active data bits. A mismatch sets the internal error bit.
- STOP: sample 1 or 2 stop bits. Any low sample sets the internal stop-error bit; remaining stop bits are still sampled.
- Frame end, on the cycle of the final stop sample:
  - Register `DataOut`, `ParityError`, and `StopError`.
  - Pulse `DataValid` on the next `Clock`.
  - Set `ActiveFlag`=0 and `DoneFlag`=1.
- After frame end: go to WAIT_HIGH if `StopError`, otherwise IDLE. WAIT_HIGH blocks re-arm until the synchronised line has been high for one full bit period, which handles break conditions.
- `DataOut`, `ParityError`, and `StopError` hold until the next frame end. Errors never suppress `DataValid`.
- Width rules:
  - Tick counter is `$clog2(OVERSAMPLE)` bits and wraps at `OVERSAMPLE-1`.
  - Bit counter is 3 bits.
  - Shift register is 8 bits. In 7-bit mode the result is right-aligned with a 0 MSB.

## Timing
- `RxIn` to internal line: `SYNC_STAGES` `Clock` cycles of latency.
- Start confirmation: `OVERSAMPLE/2` ticks after the detected edge, so all later samples fall mid-bit.
- `DataValid` asserts exactly 1 `Clock` after the `SampleTick` that samples the last stop bit. It is never asserted in consecutive cycles.
- Frame length in ticks: `OVERSAMPLE/2` + `OVERSAMPLE` × (data + parity + stop bits).
- Without ticks, the FSM holds state; only the edge detector in IDLE reacts to `Clock`.
- Back-to-back frames: a start edge arriving one tick after the last stop sample is captured.
- `Reset` mid-frame: on the next edge, go to IDLE, return all outputs to reset values, and discard the partial frame.

## Structure
- Package `uart_rx_pkg`:
  - state enum `rx_state_t`;
  - parity encodings `PAR_NONE0`, `PAR_ODD`, `PAR_EVEN`, `PAR_NONE3`;
  - default `OVERSAMPLE`.
- Sub-module `uart_rx_sync`: `SYNC_STAGES` flop chain with idle-high reset plus a falling-edge detect output. Everything else lives in `uart_rx_deframer`.

## Test plan
- 8N1, byte 0xA5, ideal timing → `DataOut`=0xA5, one `DataValid` pulse, both errors 0, `ActiveFlag` high only during the frame.
- 7-bit, even parity, 2 stop bits, data 0x41, parity bit 0 → `DataOut`=0x41, `ParityError`=0. Repeat with parity bit 1 → `ParityError`=1, `DataValid` still pulses.
- 8O1, data 0x00, stop bit driven low → `StopError`=1, FSM enters WAIT_HIGH, and a falling edge before the line has been high for one bit is ignored.
- 3-tick low glitch on an idle line → no `ActiveFlag`, no `DataValid`, `DoneFlag` stays 1.
- Frames 0x55 then 0xAA back-to-back with a zero-gap start → two `DataValid` pulses, correct values in order.
- `Reset` asserted during data bit 4 → all outputs at reset values on the next cycle. A subsequent 0x3C frame is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_pkg                                                  |
// | Description : Shared types and constants for the UART receive deframer:   |
// |               FSM state encoding, parity-type encodings and the default   |
// |               oversampling ratio.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  // ParityType encodings; both "none" codes disable the parity bit
  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;

  localparam int DEFAULT_OVERSAMPLE = 16;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_sync                                                 |
// | Description : Metastability synchroniser for the asynchronous serial line |
// |               plus a falling-edge detector on the synchronised value.     |
// |               All flops reset to the idle-high line level so that reset   |
// |               never manufactures a start edge.                            |
// | Ports       : clk      - system clock                                     |
// |               rst      - synchronous active-high reset                    |
// |               rx_async - raw serial input                                 |
// |               line     - synchronised line level                          |
// |               fall     - one-cycle pulse on a high-to-low transition       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_async,
  output logic line,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   line_d;

  generate
    if (SYNC_STAGES == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) chain <= 1'b1;
        else     chain <= rx_async;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) chain <= '1;
        else     chain <= {chain[SYNC_STAGES-2:0], rx_async};
      end
    end
  endgenerate

  assign line = chain[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) line_d <= 1'b1;
    else     line_d <= line;
  end

  assign fall = line_d & ~line;

endmodule
`default_nettype wire

// File: rtl/uart_rx_deframer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_deframer                                             |
// | Description : Oversampling UART receiver. Detects the start bit, shifts in |
// |               7 or 8 data bits LSB first, checks optional parity, checks  |
// |               1 or 2 stop bits and presents the byte with status flags.   |
// | Ports       : Clock, Reset (sync, active-high)                            |
// |               SampleTick  - one-cycle pulse at OVERSAMPLE x baud          |
// |               RxIn        - asynchronous serial line, idle high           |
// |               ParityType  - 00/11 none, 01 odd, 10 even                   |
// |               StopBits    - 0 one stop bit, 1 two stop bits               |
// |               DataLength  - 0 seven data bits, 1 eight data bits          |
// |               DataOut, ParityError, StopError - frame result (held)       |
// |               DataValid   - one-cycle pulse per completed frame           |
// |               ActiveFlag  - frame in progress after start confirmation    |
// |               DoneFlag    - idle and ready                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_deframer
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE  = DEFAULT_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SampleTick,
  input  logic       RxIn,
  input  logic [1:0] ParityType,
  input  logic       StopBits,
  input  logic       DataLength,
  output logic [7:0] DataOut,
  output logic       DataValid,
  output logic       ParityError,
  output logic       StopError,
  output logic       ActiveFlag,
  output logic       DoneFlag
);

  localparam int                TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  logic              line;
  logic              fall;
  rx_state_t         state;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [1:0]        par_cfg;
  logic              stop2;
  logic              len8;
  logic              par_err;
  logic              stop_err;

  logic              par_en;
  logic [2:0]        last_bit;
  logic [TICK_W-1:0] tick_next;
  logic              at_last;
  logic [7:0]        data_aligned;
  logic              stop_err_next;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (Clock),
    .rst      (Reset),
    .rx_async (RxIn),
    .line     (line),
    .fall     (fall)
  );

  assign par_en    = (par_cfg == PAR_ODD) || (par_cfg == PAR_EVEN);
  assign last_bit  = len8 ? 3'd7 : 3'd6;
  assign tick_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
  assign at_last   = SampleTick && (tick_cnt == TICK_LAST);
  // Bits enter at the MSB, so a 7-bit frame ends one place too high.
  assign data_aligned  = len8 ? shreg : {1'b0, shreg[7:1]};
  assign stop_err_next = stop_err | ~line;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_cfg     <= PAR_NONE0;
      stop2       <= 1'b0;
      len8        <= 1'b0;
      par_err     <= 1'b0;
      stop_err    <= 1'b0;
      DataOut     <= '0;
      DataValid   <= 1'b0;
      ParityError <= 1'b0;
      StopError   <= 1'b0;
      ActiveFlag  <= 1'b0;
      DoneFlag    <= 1'b1;
    end else begin
      DataValid <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            tick_cnt <= '0;
            par_cfg  <= ParityType;
            stop2    <= StopBits;
            len8     <= DataLength;
            state    <= START;
          end
        end
        START: begin
          if (SampleTick) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              if (!line) begin
                ActiveFlag <= 1'b1;
                DoneFlag   <= 1'b0;
                bit_cnt    <= '0;
                shreg      <= '0;
                par_err    <= 1'b0;
                stop_err   <= 1'b0;
                state      <= DATA;
              end else begin
                state <= IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (SampleTick) tick_cnt <= tick_next;
          if (at_last) begin
            shreg <= {line, shreg[7:1]};
            if (bit_cnt == last_bit) begin
              bit_cnt <= '0;
              state   <= par_en ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (SampleTick) tick_cnt <= tick_next;
          if (at_last) begin
            // Odd parity expects an overall XOR of 1, even expects 0.
            par_err <= ((^data_aligned) ^ line) != (par_cfg == PAR_ODD);
            state   <= STOP;
          end
        end
        STOP: begin
          if (SampleTick) tick_cnt <= tick_next;
          if (at_last) begin
            if (stop2 && (bit_cnt == 3'd0)) begin
              stop_err <= stop_err_next;
              bit_cnt  <= 3'd1;
            end else begin
              DataOut     <= data_aligned;
              ParityError <= par_err;
              StopError   <= stop_err_next;
              DataValid   <= 1'b1;
              ActiveFlag  <= 1'b0;
              DoneFlag    <= 1'b1;
              bit_cnt     <= '0;
              tick_cnt    <= '0;
              state       <= stop_err_next ? WAIT_HIGH : IDLE;
            end
          end
        end
        WAIT_HIGH: begin
          // Re-arm only after one uninterrupted high bit period (break recovery).
          if (!line) begin
            tick_cnt <= '0;
          end else if (SampleTick) begin
            tick_cnt <= tick_next;
            if (tick_cnt == TICK_LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deframer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_deframer                                          |
// | Description : Self-checking bench for uart_rx_deframer: directed vector    |
// |               table, hand-written corner sequences and random frames      |
// |               checked against a frame-level reference model.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_rx_deframer;

  localparam int OS     = 16;
  localparam int TDIV   = 4;
  localparam int BITCLK = OS * TDIV;

  logic       Clock;
  logic       Reset;
  logic       SampleTick;
  logic       RxIn;
  logic [1:0] ParityType;
  logic       StopBits;
  logic       DataLength;
  logic [7:0] DataOut;
  logic       DataValid;
  logic       ParityError;
  logic       StopError;
  logic       ActiveFlag;
  logic       DoneFlag;

  uart_rx_deframer #(
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (2)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .SampleTick  (SampleTick),
    .RxIn        (RxIn),
    .ParityType  (ParityType),
    .StopBits    (StopBits),
    .DataLength  (DataLength),
    .DataOut     (DataOut),
    .DataValid   (DataValid),
    .ParityError (ParityError),
    .StopError   (StopError),
    .ActiveFlag  (ActiveFlag),
    .DoneFlag    (DoneFlag)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    SampleTick = 1'b0;
    forever begin
      repeat (TDIV - 1) @(negedge Clock);
      SampleTick = 1'b1;
      @(negedge Clock);
      SampleTick = 1'b0;
    end
  end

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       se;
  } obs_t;

  typedef struct {
    logic       len8;
    logic [1:0] pt;
    logic       stop2;
    logic [7:0] data;
    logic       pbit;
    logic [1:0] stops;   // [0] first stop bit level, [1] second
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_se;
  } vec_t;

  int   applied     = 0;
  int   miscompares = 0;
  obs_t obs_q[$];
  bit   active_seen = 0;
  int   consec_dv   = 0;
  logic dv_prev     = 1'b0;

  // Records every DataValid pulse and watches for back-to-back pulses.
  initial begin
    forever begin
      @(negedge Clock);
      if (DataValid) obs_q.push_back({DataOut, ParityError, StopError});
      if (DataValid && dv_prev) consec_dv++;
      dv_prev = DataValid;
      if (ActiveFlag) active_seen = 1'b1;
    end
  end

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, tag, act, exp);
    end
  endtask

  function automatic obs_t model(input logic len8, input logic [1:0] pt, input logic stop2,
                                 input logic [7:0] data, input logic pbit, input logic [1:0] stops);
    obs_t r;
    int   ones;
    r.d  = len8 ? data : (data & 8'h7F);
    ones = $countones(r.d) + (pbit ? 1 : 0);
    r.pe = 1'b0;
    if (pt == 2'b01)      r.pe = ((ones % 2) == 0);
    else if (pt == 2'b10) r.pe = ((ones % 2) == 1);
    r.se = (stops[0] == 1'b0) || (stop2 && (stops[1] == 1'b0));
    return r;
  endfunction

  task automatic idle_clocks(input int n);
    RxIn = 1'b1;
    repeat (n) @(negedge Clock);
  endtask

  task automatic send_frame(input int tag, input logic len8, input logic [1:0] pt, input logic stop2,
                            input logic [7:0] data, input logic pbit, input logic [1:0] stops);
    logic bits[$];
    ParityType = pt;
    StopBits   = stop2;
    DataLength = len8;
    bits.push_back(1'b0);
    for (int i = 0; i < (len8 ? 8 : 7); i++) bits.push_back(data[i]);
    if (pt == 2'b01 || pt == 2'b10) bits.push_back(pbit);
    bits.push_back(stops[0]);
    if (stop2) bits.push_back(stops[1]);
    foreach (bits[k]) begin
      @(negedge Clock);
      RxIn = bits[k];
      repeat (BITCLK / 2) @(negedge Clock);
      if (k == 1) begin
        check("active_mid", tag, 32'(ActiveFlag), 32'd1);
        check("done_mid", tag, 32'(DoneFlag), 32'd0);
      end
      repeat (BITCLK / 2 - 1) @(negedge Clock);
      if (k == 0) begin
        // Scramble configuration mid-frame; the latched copy must win.
        ParityType = 2'($urandom);
        StopBits   = 1'($urandom);
        DataLength = 1'($urandom);
      end
    end
  endtask

  task automatic check_frame(input int tag, input obs_t exp);
    check("dv_count", tag, 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      check("data", tag, 32'(obs_q[0].d), 32'(exp.d));
      check("parity_err", tag, 32'(obs_q[0].pe), 32'(exp.pe));
      check("stop_err", tag, 32'(obs_q[0].se), 32'(exp.se));
    end
    check("active_end", tag, 32'(ActiveFlag), 32'd0);
    check("done_end", tag, 32'(DoneFlag), 32'd1);
    obs_q.delete();
    active_seen = 1'b0;
  endtask

  task automatic check_reset_values(input int tag);
    check("rst_data", tag, 32'(DataOut), 32'h0);
    check("rst_valid", tag, 32'(DataValid), 32'd0);
    check("rst_perr", tag, 32'(ParityError), 32'd0);
    check("rst_serr", tag, 32'(StopError), 32'd0);
    check("rst_active", tag, 32'(ActiveFlag), 32'd0);
    check("rst_done", tag, 32'(DoneFlag), 32'd1);
  endtask

  vec_t tbl[9];

  initial begin
    obs_t       e;
    logic       r_len8, r_stop2, r_pbit;
    logic [1:0] r_pt, r_stops;
    logic [7:0] r_data;

    tbl[0] = '{1'b1, 2'b00, 1'b0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 2'b10, 1'b1, 8'h41, 1'b0, 2'b11, 8'h41, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 2'b10, 1'b1, 8'h41, 1'b1, 2'b11, 8'h41, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 2'b00, 1'b0, 8'hC1, 1'b0, 2'b11, 8'h41, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 2'b01, 1'b1, 8'hFF, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 2'b10, 1'b0, 8'h80, 1'b0, 2'b11, 8'h80, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 2'b11, 1'b0, 8'h3C, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 2'b00, 1'b1, 8'h5A, 1'b0, 2'b01, 8'h5A, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 2'b01, 1'b0, 8'h7F, 1'b1, 2'b10, 8'h7F, 1'b1, 1'b1};

    Reset      = 1'b1;
    RxIn       = 1'b1;
    ParityType = 2'b00;
    StopBits   = 1'b0;
    DataLength = 1'b1;
    repeat (5) @(negedge Clock);
    check_reset_values(0);
    Reset = 1'b0;
    idle_clocks(BITCLK);

    // Directed table
    foreach (tbl[i]) begin
      send_frame(100 + i, tbl[i].len8, tbl[i].pt, tbl[i].stop2, tbl[i].data, tbl[i].pbit, tbl[i].stops);
      e.d = tbl[i].exp_d; e.pe = tbl[i].exp_pe; e.se = tbl[i].exp_se;
      check_frame(100 + i, e);
      idle_clocks(2 * BITCLK);
    end

    // Stop error then an early falling edge that WAIT_HIGH must ignore
    send_frame(200, 1'b1, 2'b01, 1'b0, 8'h00, 1'b1, 2'b00);
    e.d = 8'h00; e.pe = 1'b0; e.se = 1'b1;
    check_frame(200, e);
    idle_clocks(4 * TDIV);
    RxIn = 1'b0;
    repeat (2 * BITCLK) @(negedge Clock);
    check("wait_high_active", 200, 32'(active_seen), 32'd0);
    idle_clocks(2 * BITCLK);
    check("wait_high_dv", 200, 32'(obs_q.size()), 32'd0);
    send_frame(201, 1'b1, 2'b00, 1'b0, 8'h96, 1'b0, 2'b11);
    e.d = 8'h96; e.pe = 1'b0; e.se = 1'b0;
    check_frame(201, e);
    idle_clocks(BITCLK);

    // Short low glitch on an idle line is a false start
    active_seen = 1'b0;
    RxIn = 1'b0;
    repeat (3 * TDIV) @(negedge Clock);
    idle_clocks(2 * BITCLK);
    check("glitch_active", 300, 32'(active_seen), 32'd0);
    check("glitch_dv", 300, 32'(obs_q.size()), 32'd0);
    check("glitch_done", 300, 32'(DoneFlag), 32'd1);

    // Back-to-back frames with no idle gap
    send_frame(400, 1'b1, 2'b00, 1'b0, 8'h55, 1'b0, 2'b11);
    e.d = 8'h55; e.pe = 1'b0; e.se = 1'b0;
    check_frame(400, e);
    send_frame(401, 1'b1, 2'b00, 1'b0, 8'hAA, 1'b0, 2'b11);
    e.d = 8'hAA;
    check_frame(401, e);
    idle_clocks(BITCLK);

    // Reset during data bit 4 of a 0x3C frame
    ParityType = 2'b00; StopBits = 1'b0; DataLength = 1'b1;
    r_data = 8'h3C;
    @(negedge Clock); RxIn = 1'b0;
    repeat (BITCLK - 1) @(negedge Clock);
    for (int b = 0; b < 4; b++) begin
      RxIn = r_data[b];
      repeat (BITCLK) @(negedge Clock);
    end
    RxIn = r_data[4];
    repeat (BITCLK / 2) @(negedge Clock);
    check("pre_reset_active", 500, 32'(ActiveFlag), 32'd1);
    RxIn  = 1'b1;
    Reset = 1'b1;
    @(negedge Clock);
    check_reset_values(500);
    Reset = 1'b0;
    idle_clocks(2 * BITCLK);
    check("reset_dv", 500, 32'(obs_q.size()), 32'd0);
    send_frame(501, 1'b1, 2'b00, 1'b0, 8'h3C, 1'b0, 2'b11);
    e.d = 8'h3C; e.pe = 1'b0; e.se = 1'b0;
    check_frame(501, e);
    idle_clocks(BITCLK);

    // Random frames against the reference model
    for (int n = 0; n < 30; n++) begin
      r_len8  = 1'($urandom);
      r_pt    = 2'($urandom);
      r_stop2 = 1'($urandom);
      r_data  = 8'($urandom);
      r_pbit  = 1'($urandom);
      r_stops = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11;
      e = model(r_len8, r_pt, r_stop2, r_data, r_pbit, r_stops);
      send_frame(1000 + n, r_len8, r_pt, r_stop2, r_data, r_pbit, r_stops);
      check_frame(1000 + n, e);
      if (e.se)                          idle_clocks(2 * BITCLK);
      else if ($urandom_range(0, 2) != 0) idle_clocks($urandom_range(1, 40));
    end

    idle_clocks(BITCLK);
    check("dv_consecutive", 9999, 32'(consec_dv), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
